ddr_pattern_gen: RTL and testbench

DDR_PATTERN_GEN -- requirements
Module: ddr_pattern_gen

---
 rtl/ddr_pattern_gen_pkg.sv | 42 ++++
 rtl/ddr_pattern_gen_if.sv | 14 +
 rtl/ddr_pattern_gen_lut.sv | 49 ++++
 rtl/ddr_pattern_gen.sv | 120 ++++++++++++
 tb/tb_ddr_pattern_gen.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_pattern_gen_pkg.sv
// rtl/ddr_pattern_gen_pkg.sv - shared widths, state enum, bar colours and pattern codes
package ddr_pattern_gen_pkg;

    localparam int PIX_W        = 32;
    localparam int BEAT_W       = 512;
    localparam int PIX_PER_BEAT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] PAT_BARS    = 2'd0;
    localparam logic [1:0] PAT_RAMP    = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_SOLID   = 2'd3;

    localparam logic [PIX_W-1:0] BAR_WHITE   = 32'h00FF_FFFF;
    localparam logic [PIX_W-1:0] BAR_YELLOW  = 32'h00FF_FF00;
    localparam logic [PIX_W-1:0] BAR_CYAN    = 32'h0000_FFFF;
    localparam logic [PIX_W-1:0] BAR_GREEN   = 32'h0000_FF00;
    localparam logic [PIX_W-1:0] BAR_MAGENTA = 32'h00FF_00FF;
    localparam logic [PIX_W-1:0] BAR_RED     = 32'h00FF_0000;
    localparam logic [PIX_W-1:0] BAR_BLUE    = 32'h0000_00FF;
    localparam logic [PIX_W-1:0] BAR_BLACK   = 32'h0000_0000;

    // Bar 0 is the leftmost bar of the colour-bar pattern.
    function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/ddr_pattern_gen_if.sv
// rtl/ddr_pattern_gen_if.sv - write-port bundle between the pattern generator and the DDR write FIFO
// Signals: wr_en (beat strobe), wr_data (512-bit beat), wr_full (FIFO backpressure).
// master = beat producer, slave = write FIFO.
interface ddr_pattern_gen_if;
    import ddr_pattern_gen_pkg::*;

    logic              wr_en;
    logic [BEAT_W-1:0] wr_data;
    logic              wr_full;

    modport master (output wr_en, output wr_data, input wr_full);
    modport slave  (input wr_en, input wr_data, output wr_full);

endinterface

// File: rtl/ddr_pattern_gen_lut.sv
// rtl/ddr_pattern_gen_lut.sv - combinational beat generator for one 16-pixel beat
// Ports: pattern (pattern code), x_beat (beat column), y (line), beat (512-bit pixels, pixel 0 in bits [31:0]).
module pattern_pixel_lut
    import ddr_pattern_gen_pkg::*;
#(
    parameter int  H_ACTIVE       = 1920,
    parameter int  V_ACTIVE       = 1080,
    localparam int BEATS_PER_LINE = H_ACTIVE / PIX_PER_BEAT,
    localparam int XW             = $clog2(BEATS_PER_LINE),
    localparam int YW             = $clog2(V_ACTIVE)
) (
    input  logic [1:0]        pattern,
    input  logic [XW-1:0]     x_beat,
    input  logic [YW-1:0]     y,
    output logic [BEAT_W-1:0] beat
);

    // H_ACTIVE is a multiple of 128, so every bar spans a whole number of
    // beats and one beat never straddles two bars.
    localparam int BAR_BEATS = BEATS_PER_LINE / 8;

    logic [2:0] bar_idx;
    logic       unused_y;

    // Only the line parity matters to the patterns.
    assign unused_y = ^y;

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (int'(x_beat) >= i * BAR_BEATS) begin
                bar_idx = 3'(i);
            end
        end
    end

    always_comb begin
        beat = '0;
        for (int k = 0; k < PIX_PER_BEAT; k++) begin
            case (pattern)
                PAT_BARS:    beat[k*PIX_W +: PIX_W] = bar_color(bar_idx);
                PAT_RAMP:    beat[k*PIX_W +: PIX_W] = {8'h00, {3{8'(32'(x_beat) * 16 + k)}}};
                PAT_CHECKER: beat[k*PIX_W +: PIX_W] = (x_beat[0] ^ y[0]) ? BAR_WHITE : BAR_BLACK;
                default:     beat[k*PIX_W +: PIX_W] = BAR_RED;
            endcase
        end
    end

endmodule

// File: rtl/ddr_pattern_gen.sv
// rtl/ddr_pattern_gen.sv - test-frame source: one frame of 512-bit beats per start request
// Ports: clk, rst (sync, active-high), start, pattern_sel, wr_if (master: wr_en/wr_data out, wr_full in),
// busy (not idle), frame_done (end-of-frame pulse), frame_cnt (completed frames, wraps).
module ddr_pattern_gen
    import ddr_pattern_gen_pkg::*;
#(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               pattern_sel,
    ddr_pattern_gen_if.master        wr_if,
    output logic                     busy,
    output logic                     frame_done,
    output logic [7:0]               frame_cnt
);

    localparam int BEATS_PER_LINE = H_ACTIVE / PIX_PER_BEAT;
    localparam int XW             = $clog2(BEATS_PER_LINE);
    localparam int YW             = $clog2(V_ACTIVE);
    localparam logic [XW-1:0] X_LAST = XW'(BEATS_PER_LINE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [1:0]        pat_q, pat_d;
    logic              wr_en_q, wr_en_d;
    logic [BEAT_W-1:0] wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic [BEAT_W-1:0] beat;

    pattern_pixel_lut #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_lut (
        .pattern (pat_q),
        .x_beat  (x_q),
        .y       (y_q),
        .beat    (beat)
    );

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        pat_d        = pat_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pat_d   = pattern_sel;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Counters only move on an issued beat, so a stalled cycle
                // re-presents the same (x, y) on the next edge.
                if (!wr_if.wr_full) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = beat;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = ST_DONE;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            ST_DONE: begin
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 8'd1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            pat_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pat_q        <= pat_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign wr_if.wr_en   = wr_en_q;
    assign wr_if.wr_data = wr_data_q;
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = frame_done_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_ddr_pattern_gen.sv
// tb/tb_ddr_pattern_gen.sv - self-checking bench for ddr_pattern_gen (256 x 4 frame)
module tb_ddr_pattern_gen;

    localparam int H_ACT = 256;
    localparam int V_ACT = 4;
    localparam int BPL   = H_ACT / 16;
    localparam int NBEAT = BPL * V_ACT;
    localparam logic [31:0] BARS [8] = '{32'h00FFFFFF, 32'h00FFFF00, 32'h0000FFFF, 32'h0000FF00,
                                         32'h00FF00FF, 32'h00FF0000, 32'h000000FF, 32'h00000000};

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] pattern_sel;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_cnt;

    ddr_pattern_gen_if wr_if ();

    ddr_pattern_gen #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pattern_sel (pattern_sel),
        .wr_if       (wr_if),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          pat;
        int          xb;
        int          y;
        logic [31:0] pix0;
        logic [31:0] step;
    } vec_t;

    vec_t         tbl[$];
    logic [511:0] beats[$];
    int           done_cnt;
    int           bp_mode;
    int           n_cmp = 0;
    int           n_err = 0;
    logic [7:0]   exp_cnt;

    always @(negedge clk) begin
        if (wr_if.wr_en) beats.push_back(wr_if.wr_data);
        if (frame_done) done_cnt++;
    end

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            1:       wr_if.wr_full = ~wr_if.wr_full;
            2:       wr_if.wr_full = ($urandom_range(0, 3) == 0);
            default: wr_if.wr_full = 1'b0;
        endcase
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    function automatic logic [511:0] ref_beat(int pat, int xb, int y);
        logic [511:0] b;
        b = '0;
        for (int k = 0; k < 16; k++) begin
            int x;
            x = 16 * xb + k;
            case (pat)
                0:       b[k*32 +: 32] = BARS[x / (H_ACT / 8)];
                1:       b[k*32 +: 32] = {8'h00, x[7:0], x[7:0], x[7:0]};
                2:       b[k*32 +: 32] = (((xb + y) % 2) == 1) ? 32'h00FFFFFF : 32'h0;
                default: b[k*32 +: 32] = 32'h00FF0000;
            endcase
        end
        return b;
    endfunction

    task automatic check_v(string name, logic [511:0] act, logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(int pat);
        start       = 1'b1;
        pattern_sel = 2'(pat);
        step();
        start       = 1'b0;
        pattern_sel = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_beats(int n);
        int cyc = 0;
        while (beats.size() < n && cyc < 2000) begin
            step();
            cyc++;
        end
        if (beats.size() < n) check_v("beat_wait_timeout", 512'(beats.size()), 512'(n));
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (done_cnt == 0 && cyc < 2000) begin
            step();
            cyc++;
        end
        if (done_cnt == 0) check_v("frame_done_timeout", 0, 1);
    endtask

    task automatic check_frame(int pat);
        check_v("beat_count", 512'(beats.size()), 512'(NBEAT));
        for (int i = 0; i < beats.size() && i < NBEAT; i++) begin
            check_v($sformatf("beat%0d_pat%0d", i, pat), beats[i], ref_beat(pat, i % BPL, i / BPL));
        end
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].pat == pat) begin
                int idx;
                logic [511:0] exp;
                logic [511:0] act;
                idx = tbl[i].y * BPL + tbl[i].xb;
                for (int k = 0; k < 16; k++) exp[k*32 +: 32] = tbl[i].pix0 + 32'(k) * tbl[i].step;
                act = (idx < beats.size()) ? beats[idx] : 'x;
                check_v(tbl[i].name, act, exp);
            end
        end
    endtask

    task automatic run_frame(int pat);
        beats.delete();
        done_cnt = 0;
        pulse_start(pat);
        wait_done();
        exp_cnt = exp_cnt + 8'd1;
        check_v("frame_done_count", 512'(done_cnt), 1);
        check_v("frame_cnt", 512'(frame_cnt), 512'(exp_cnt));
        check_frame(pat);
    endtask

    initial begin
        int consec;

        tbl.push_back('{"bars_beat0",      0,  0, 0, 32'h00FFFFFF, 32'h0});
        tbl.push_back('{"bars_beat1",      0,  1, 0, 32'h00FFFFFF, 32'h0});
        tbl.push_back('{"bars_beat2",      0,  2, 0, 32'h00FFFF00, 32'h0});
        tbl.push_back('{"bars_beat3",      0,  3, 0, 32'h00FFFF00, 32'h0});
        tbl.push_back('{"bars_beat4_y1",   0,  4, 1, 32'h0000FFFF, 32'h0});
        tbl.push_back('{"bars_beat14",     0, 14, 0, 32'h00000000, 32'h0});
        tbl.push_back('{"bars_beat15_y3",  0, 15, 3, 32'h00000000, 32'h0});
        tbl.push_back('{"ramp_x3",         1,  3, 0, 32'h00303030, 32'h00010101});
        tbl.push_back('{"ramp_x15_y2",     1, 15, 2, 32'h00F0F0F0, 32'h00010101});
        tbl.push_back('{"checker_0_0",     2,  0, 0, 32'h00000000, 32'h0});
        tbl.push_back('{"checker_1_0",     2,  1, 0, 32'h00FFFFFF, 32'h0});
        tbl.push_back('{"checker_0_1",     2,  0, 1, 32'h00FFFFFF, 32'h0});
        tbl.push_back('{"checker_1_1",     2,  1, 1, 32'h00000000, 32'h0});
        tbl.push_back('{"solid_x7_y2",     3,  7, 2, 32'h00FF0000, 32'h0});

        rst = 1'b1; start = 1'b0; pattern_sel = 2'd0; bp_mode = 0; wr_if.wr_full = 1'b0;
        exp_cnt = 8'd0; done_cnt = 0;
        step(); step(); step();
        check_v("rst_wr_en", 512'(wr_if.wr_en), 0);
        check_v("rst_busy", 512'(busy), 0);
        check_v("rst_frame_done", 512'(frame_done), 0);
        check_v("rst_frame_cnt", 512'(frame_cnt), 0);
        check_v("rst_wr_data", wr_if.wr_data, '0);
        rst = 1'b0;
        step();

        // Bars, no backpressure: 64 back-to-back beats one cycle after acceptance.
        beats.delete(); done_cnt = 0;
        pulse_start(0);
        check_v("bars_wr_en_at_accept", 512'(wr_if.wr_en), 0);
        check_v("bars_busy", 512'(busy), 1);
        step();
        consec = 0;
        for (int i = 0; i < NBEAT; i++) begin
            if (wr_if.wr_en) consec++;
            step();
        end
        check_v("bars_consecutive", 512'(consec), 512'(NBEAT));
        check_v("bars_wr_en_after", 512'(wr_if.wr_en), 0);
        check_v("bars_frame_done", 512'(frame_done), 1);
        check_v("bars_frame_cnt", 512'(frame_cnt), 1);
        exp_cnt = 8'd1;
        check_frame(0);
        step();

        // Ramp with wr_full toggling every cycle.
        bp_mode = 1;
        run_frame(1);

        // Start pulsed again mid-frame must be ignored.
        bp_mode = 2;
        beats.delete(); done_cnt = 0;
        pulse_start(0);
        wait_beats(20);
        pulse_start(3);
        wait_done();
        repeat (10) step();
        exp_cnt = exp_cnt + 8'd1;
        check_v("busy_start_done_count", 512'(done_cnt), 1);
        check_v("busy_start_frame_cnt", 512'(frame_cnt), 512'(exp_cnt));
        check_v("busy_start_idle", 512'(busy), 0);
        check_frame(0);

        // Reset mid-frame aborts without frame_done; next frame restarts at (0,0).
        beats.delete(); done_cnt = 0;
        pulse_start(0);
        wait_beats(30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_v("midrst_wr_en", 512'(wr_if.wr_en), 0);
        check_v("midrst_busy", 512'(busy), 0);
        check_v("midrst_frame_cnt", 512'(frame_cnt), 0);
        check_v("midrst_frame_done", 512'(frame_done), 0);
        repeat (5) step();
        check_v("midrst_no_done", 512'(done_cnt), 0);
        exp_cnt = 8'd0;
        run_frame(3);

        // Random patterns under random backpressure.
        for (int f = 0; f < 6; f++) run_frame(int'($urandom_range(0, 3)));

        // 256 checker frames: frame_cnt wraps back to zero.
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 8'd0;
        bp_mode = 0;
        step();
        for (int f = 0; f < 256; f++) run_frame(2);
        check_v("wrap_frame_cnt", 512'(frame_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
